// File: rtl/fifo_flags.sv
// -----------------------------------------------------------------------------
// fifo_flags
//
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds and one-cycle overflow / underflow error pulses.
// DEPTH may be any integer >= 2; the pointers wrap by explicit compare, so
// non-power-of-two depths behave correctly.
//
// Compile-time option:
//   FIFO_FWFT_EN defined   -> first-word-fall-through: dataOut shows the head
//                             word combinationally while not empty, 0 when
//                             empty; RD pops the word currently shown.
//   FIFO_FWFT_EN undefined -> registered read: an accepted RD loads the head
//                             word into dataOut at that edge; dataOut holds
//                             otherwise.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rstn         in   asynchronous active-low reset
//   dataIn       in   write data [DATA_WIDTH]
//   WR           in   write request
//   RD           in   read request
//   dataOut      out  read data [DATA_WIDTH]
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almostFull   out  count >= AF_LEVEL
//   almostEmpty  out  count <= AE_LEVEL
//   count        out  occupancy 0..DEPTH [$clog2(DEPTH+1)]
//   overflow     out  one-cycle pulse after a rejected write
//   underflow    out  one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module fifo_flags #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  WR,
    input  logic                  RD,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  full,
    output logic                  empty,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_ok;
    logic                  w_rd_ok;

    // Explicit wrap so that DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flags are decoded from the registered count only.
    assign full        = (r_count == CW'(DEPTH));
    assign empty       = (r_count == '0);
    assign almostFull  = (r_count >= CW'(AF_LEVEL));
    assign almostEmpty = (r_count <= CW'(AE_LEVEL));
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // A write into a full FIFO is still accepted when a read frees the head
    // slot on the same edge; that slot is exactly the one being written.
    assign w_wr_ok = WR && (!full || RD);
    assign w_rd_ok = RD && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - 1'b1;
            end
            r_overflow  <= WR && !w_wr_ok;
            r_underflow <= RD && !w_rd_ok;
        end
    end

    // Storage is deliberately not reset; after reset the pointers make old
    // contents unreachable.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= dataIn;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; RD acknowledges it.
    assign dataOut = empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    // On a full simultaneous read/write the memory write lands on this same
    // slot, but the non-blocking update means the old word is captured here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_out <= '0;
        end else if (w_rd_ok) begin
            r_data_out <= r_mem[r_rd_ptr];
        end
    end

    assign dataOut = r_data_out;
`endif

endmodule
